// File: rtl/cpu_contention_pkg.sv
// Purpose: shared raster timing constants and contention decode helpers for the ULA-style video/CPU path.
// Latency: n/a (constants and pure combinational functions).
// Backpressure: n/a.
// Contents: cnt_t counter type, frame geometry (448x312, 256x192 display), interrupt line/length,
//           contended_slot() and contended_access() decode helpers.
package cpu_contention_pkg;

   typedef logic [8:0] cnt_t;

   localparam cnt_t HTOTAL   = 9'd448;
   localparam cnt_t VTOTAL   = 9'd312;
   localparam cnt_t HDISP    = 9'd256;
   localparam cnt_t VDISP    = 9'd192;
   localparam cnt_t INT_LINE = 9'd248;
   localparam cnt_t INT_LEN  = 9'd64;

   localparam cnt_t H_LAST   = HTOTAL - 9'd1;
   localparam cnt_t V_LAST   = VTOTAL - 9'd1;

   // Inside the display window the ULA owns 12 of every 16 pixels; the last
   // 4 pixels of each 16-pixel group (hc[3:2]==3) are left free for the CPU.
   function automatic logic contended_slot(input cnt_t hc, input cnt_t vc);
      return (vc < VDISP) && (hc < HDISP) && (hc[3:2] != 2'b11);
   endfunction

   // Memory or I/O to the 0x4000-0x7FFF page, or any even I/O port (the ULA
   // decodes only a[0]), collides with the ULA.
   function automatic logic contended_access(input logic [1:0] page,
                                             input logic       a0,
                                             input logic       mreq_n,
                                             input logic       iorq_n);
      logic ula_page;
      ula_page = (page == 2'b01);
      return (!mreq_n && ula_page) || (!iorq_n && ula_page) || (!iorq_n && !a0);
   endfunction

endpackage

// File: rtl/cpu_contention_ula_counters.sv
// Purpose: horizontal/vertical raster counters for a 448x312 pixel frame, shared by video and CPU timing.
// Latency: counters move on the clk edge where ce=1; hc_nxt/vc_nxt are the combinational next values.
// Backpressure: none; free-running, gated only by ce.
// Ports: clk, rst (async, active-high), ce (pixel enable) -> hc, vc (registered), hc_nxt, vc_nxt.
module ula_counters
   import cpu_contention_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic ce,
   output cnt_t hc,
   output cnt_t vc,
   output cnt_t hc_nxt,
   output cnt_t vc_nxt
);

   always_comb begin
      hc_nxt = hc;
      vc_nxt = vc;
      if (ce) begin
         if (hc == H_LAST) begin
            hc_nxt = '0;
            vc_nxt = (vc == V_LAST) ? '0 : vc + 9'd1;
         end else begin
            hc_nxt = hc + 9'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc <= '0;
         vc <= '0;
      end else begin
         hc <= hc_nxt;
         vc <= vc_nxt;
      end
   end

endmodule

// File: rtl/cpu_contention.sv
// Purpose: ULA memory/IO contention model and frame interrupt for a 3.5 MHz CPU on a 7 MHz pixel clock.
// Latency: CPUContention one clk after bus/position change; int_n moves with the counters on clk7en edges.
// Backpressure: none; CPUContention is advisory (suppresses the CPU enable), counters never stall.
// Ports: clk, rst, clk7en, contention_on, a[15:0], mreq_n, iorq_n -> CPUContention, int_n, hc[8:0], vc[8:0].
module cpu_contention
   import cpu_contention_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clk7en,
   input  logic        contention_on,
   input  logic [15:0] a,
   input  logic        mreq_n,
   input  logic        iorq_n,
   output logic        CPUContention,
   output logic        int_n,
   output logic [8:0]  hc,
   output logic [8:0]  vc
);

   cnt_t hc_nxt;
   cnt_t vc_nxt;
   logic contend_now;
   logic unused_addr;

   // Only the page bits and a[0] take part in the ULA decode.
   assign unused_addr = ^a[13:1];

   ula_counters u_counters (
      .clk    (clk),
      .rst    (rst),
      .ce     (clk7en),
      .hc     (hc),
      .vc     (vc),
      .hc_nxt (hc_nxt),
      .vc_nxt (vc_nxt)
   );

   assign contend_now = contention_on
                      && contended_slot(hc, vc)
                      && contended_access(a[15:14], a[0], mreq_n, iorq_n);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         CPUContention <= 1'b0;
         int_n         <= 1'b1;
      end else begin
         // Re-evaluated every clk so a bus release drops contention without
         // waiting for the next pixel enable.
         CPUContention <= contend_now;
         // Decoded from the next counter values so int_n lines up with hc/vc.
         if (clk7en) begin
            int_n <= !((vc_nxt == INT_LINE) && (hc_nxt < INT_LEN));
         end
      end
   end

endmodule

// File: tb/tb_cpu_contention.sv
module tb_cpu_contention;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk7en;
   logic        contention_on;
   logic [15:0] a;
   logic        mreq_n;
   logic        iorq_n;
   logic        CPUContention;
   logic        int_n;
   logic [8:0]  hc;
   logic [8:0]  vc;

   int n_checks = 0;
   int n_pass   = 0;

   // reference raster model
   int m_hc = 0;
   int m_vc = 0;
   bit m_int = 1'b1;

   bit exp_q[$];

   int int_cnt = 0;
   int int_first_v = -1;
   int int_first_h = -1;

   cpu_contention dut (
      .clk           (clk),
      .rst           (rst),
      .clk7en        (clk7en),
      .contention_on (contention_on),
      .a             (a),
      .mreq_n        (mreq_n),
      .iorq_n        (iorq_n),
      .CPUContention (CPUContention),
      .int_n         (int_n),
      .hc            (hc),
      .vc            (vc)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (model hc=%0d vc=%0d)", tag, got, exp, m_hc, m_vc);
   endtask

   function automatic bit m_slot(input int h, input int v);
      return (v < 192) && (h < 256) && (((h >> 2) & 3) != 3);
   endfunction

   function automatic bit m_access(input logic [15:0] ad, input logic mq, input logic iq);
      return (!mq && ad[15:14] == 2'b01) || (!iq && ad[15:14] == 2'b01) || (!iq && !ad[0]);
   endfunction

   task automatic model_reset();
      m_hc = 0;
      m_vc = 0;
      m_int = 1'b1;
   endtask

   task automatic model_advance();
      m_hc++;
      if (m_hc == 448) begin
         m_hc = 0;
         m_vc++;
         if (m_vc == 312) m_vc = 0;
      end
      m_int = !(m_vc == 248 && m_hc < 64);
   endtask

   // One clk: drive at negedge, score the registered contention just after the edge.
   task automatic step(input logic en, input logic con, input logic [15:0] ad,
                       input logic mq, input logic iq, input bit chk);
      bit e;
      clk7en = en;
      contention_on = con;
      a = ad;
      mreq_n = mq;
      iorq_n = iq;
      if (chk) exp_q.push_back(con && m_slot(m_hc, m_vc) && m_access(ad, mq, iq));
      if (en) model_advance();
      @(posedge clk);
      #1;
      if (chk) begin
         e = exp_q.pop_front();
         check_val("contention", 32'(CPUContention), 32'(e));
      end
      @(negedge clk);
   endtask

   // Bus stimulus for a raster position, in 16-pixel segments.
   task automatic bus_for(input int v, input int h, output logic con, output logic [15:0] ad,
                          output logic mq, output logic iq, output bit chk);
      int seg;
      seg = h / 16;
      con = 1'b1; ad = 16'h0000; mq = 1'b1; iq = 1'b1; chk = 1'b0;
      if (v == 10) begin
         chk = 1'b1;
         case (seg)
            0:       begin mq = 1'b0; ad = 16'h4000; end
            1:       begin mq = 1'b0; ad = 16'h8000; end
            2:       begin mq = 1'b0; ad = 16'h0000; end
            3:       begin iq = 1'b0; ad = 16'h00FE; end
            4:       begin iq = 1'b0; ad = 16'h00FF; end
            5:       begin mq = 1'b0; iq = 1'b0; ad = 16'h4001; end
            6:       begin con = 1'b0; mq = 1'b0; ad = 16'h4000; end
            7, 8:    begin mq = 1'b0; ad = 16'h4000; end
            19:      begin mq = 1'b0; ad = 16'h4000; end
            default: chk = 1'b0;
         endcase
      end else if ((v == 0 || v == 191 || v == 192) && seg == 0) begin
         chk = 1'b1;
         mq = 1'b0;
         ad = 16'h4000;
      end
   endtask

   initial begin
      logic        con;
      logic [15:0] ad;
      logic        mq;
      logic        iq;
      bit          chk;

      // reset with a contended bus present: outputs must still be forced
      rst = 1'b1;
      clk7en = 1'b1;
      contention_on = 1'b1;
      a = 16'h4000;
      mreq_n = 1'b0;
      iorq_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_hc", 32'(hc), 32'd0);
      check_val("rst_vc", 32'(vc), 32'd0);
      check_val("rst_int", 32'(int_n), 32'd1);
      check_val("rst_contention", 32'(CPUContention), 32'd0);
      clk7en = 1'b0;
      mreq_n = 1'b1;
      rst = 1'b0;

      // one full frame, clk7en every 2nd clk
      for (int v = 0; v < 312; v++) begin
         for (int h = 0; h < 448; h++) begin
            bus_for(v, h, con, ad, mq, iq, chk);
            step(1'b0, con, ad, mq, iq, chk);
            if (v == 10 && h == 128) begin
               repeat (6) step(1'b0, con, ad, mq, iq, chk);
               check_val("freeze_hc", 32'(hc), 32'd128);
               check_val("freeze_vc", 32'(vc), 32'd10);
            end
            step(1'b1, con, ad, mq, iq, chk);
            if (m_hc == 0) begin
               check_val("line_hc", 32'(hc), 32'(m_hc));
               check_val("line_vc", 32'(vc), 32'(m_vc));
            end
            if (v >= 247 && v <= 249) check_val("int_n", 32'(int_n), 32'(m_int));
            if (int_n == 1'b0) begin
               if (int_cnt == 0) begin
                  int_first_v = m_vc;
                  int_first_h = m_hc;
               end
               int_cnt++;
            end
         end
      end
      check_val("wrap_hc", 32'(hc), 32'd0);
      check_val("wrap_vc", 32'(vc), 32'd0);
      check_val("int_len", 32'(int_cnt), 32'd64);
      check_val("int_first_vc", 32'(int_first_v), 32'd248);
      check_val("int_first_hc", 32'(int_first_h), 32'd0);

      // reset in the middle of contention
      repeat (3) step(1'b1, 1'b1, 16'h4000, 1'b0, 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_val("midcont_contention", 32'(CPUContention), 32'd0);
      check_val("midcont_hc", 32'(hc), 32'd0);
      model_reset();
      mreq_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // fast-forward to vc=248, hc=30 and reset mid-interrupt
      for (int i = 0; i < 248 * 448 + 30; i++) step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
      check_val("pos_hc", 32'(hc), 32'd30);
      check_val("pos_vc", 32'(vc), 32'd248);
      check_val("midint_int_before", 32'(int_n), 32'(m_int));
      #2 rst = 1'b1;
      #1;
      check_val("midint_int", 32'(int_n), 32'd1);
      check_val("midint_contention", 32'(CPUContention), 32'd0);
      check_val("midint_hc", 32'(hc), 32'd0);
      check_val("midint_vc", 32'(vc), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b1, 16'h4000, 1'b0, 1'b1, 1'b1);
      check_val("restart_hc", 32'(hc), 32'(m_hc));
      check_val("restart_vc", 32'(vc), 32'(m_vc));
      check_val("restart_int", 32'(int_n), 32'(m_int));
      check_val("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
